// File: rtl/cpu_datapath.sv
// Single-bus 32-bit datapath: register file, PC/IR, MAR/MDR with 512x32 RAM, Y/Z/HI/LO,
// opcode-decoded ALU, select/encode, CON-FF and I/O ports. Optional macro MULDIV_EN enables mul/div.
module cpu_datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        IncPC,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        MARin,
  input  logic        MDRout,
  input  logic        MDRin,
  input  logic        memRead,
  input  logic        ramEnable,
  input  logic        PCin,
  input  logic        PCout,
  input  logic        ADD,
  input  logic        Zin,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Yin,
  input  logic        IRin,
  input  logic        Cout,
  input  logic [31:0] InPortData,
  input  logic        InPort_Out,
  output logic [31:0] OutPortData,
  input  logic        OutPort_In,
  input  logic        CONin,
  output logic        CON
);

  localparam int unsigned W         = 32;
  localparam int unsigned NREG      = 16;
  localparam int unsigned AW        = 9;
  localparam int unsigned RAM_DEPTH = 512;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;

  logic [W-1:0]    rf_q [NREG];
  logic [W-1:0]    rf_d [NREG];
  logic [W-1:0]    pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, y_q, y_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d, inport_q, outport_q, outport_d;
  logic [2*W-1:0]  z_q, z_d;
  logic [AW-1:0]   mar_q, mar_d;
  logic            con_q, con_d;
  logic [W-1:0]    mem_q [RAM_DEPTH];

  logic [NREG-1:0] man_out, man_in, sel_dec, reg_out, reg_in;
  logic [3:0]      fld;
  logic            r0_zero;
  logic [W-1:0]    bus, c_sext, alu_lo, alu_hi;
  logic [4:0]      opcode, alu_op, amt;
  logic [2*W-1:0]  dbl;
  logic            con_eval;

  assign man_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign man_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  assign opcode = ir_q[31:27];
  assign c_sext = {{(W-19){ir_q[18]}}, ir_q[18:0]};

  // Select/encode: Gra > Grb > Grc picks the IR field that Rin/Rout/BAout act on
  always_comb begin
    fld = 4'd0;
    if (Gra)      fld = ir_q[26:23];
    else if (Grb) fld = ir_q[22:19];
    else if (Grc) fld = ir_q[18:15];
  end

  assign sel_dec = (Gra | Grb | Grc) ? (NREG'(1) << fld) : '0;
  assign reg_in  = man_in  | ({NREG{Rin}} & sel_dec);
  assign reg_out = man_out | ({NREG{Rout | BAout}} & sel_dec);
  assign r0_zero = BAout & sel_dec[0] & ~Rout & ~R0out;

  // Bus mux: later assignments override, so the lowest-listed source has highest priority
  always_comb begin
    bus = '0;
    if (Cout)        bus = c_sext;
    if (InPort_Out)  bus = inport_q;
    if (MDRout)      bus = mdr_q;
    if (PCout)       bus = pc_q;
    if (Zlowout)     bus = z_q[W-1:0];
    if (Zhighout)    bus = z_q[2*W-1:W];
    if (LOout)       bus = lo_q;
    if (HIout)       bus = hi_q;
    for (int i = NREG - 1; i >= 1; i--) begin
      if (reg_out[i]) bus = rf_q[i];
    end
    if (reg_out[0])  bus = r0_zero ? '0 : rf_q[0];
  end

  assign alu_op = ADD ? OP_ADD : opcode;
  assign amt    = bus[4:0];
  assign dbl    = {y_q, y_q};

`ifdef MULDIV_EN
  logic signed [2*W-1:0] mul_a, mul_b, mul_p;
  logic signed [W-1:0]   div_a, div_b;
  logic [W-1:0]          quot, rem;

  assign mul_a = {{W{y_q[W-1]}}, y_q};
  assign mul_b = {{W{bus[W-1]}}, bus};
  assign mul_p = mul_a * mul_b;
  assign div_a = y_q;
  assign div_b = bus;
  assign quot  = (bus == '0) ? '0 : W'(div_a / div_b);
  assign rem   = (bus == '0) ? '0 : W'(div_a % div_b);
`endif

  // ALU: A = Y, B = bus; hi is only non-zero for mul/div
  always_comb begin
    alu_lo = y_q + bus;
    alu_hi = '0;
    case (alu_op)
      OP_ADD, OP_ADDI: alu_lo = y_q + bus;
      OP_SUB:          alu_lo = y_q - bus;
      OP_AND, OP_ANDI: alu_lo = y_q & bus;
      OP_OR,  OP_ORI:  alu_lo = y_q | bus;
      OP_ROR:          alu_lo = W'(dbl >> amt);
      OP_ROL:          alu_lo = W'((dbl << amt) >> W);
      OP_SHR:          alu_lo = y_q >> amt;
      OP_SHRA:         alu_lo = W'($signed(y_q) >>> amt);
      OP_SHL:          alu_lo = y_q << amt;
`ifdef MULDIV_EN
      OP_DIV: begin
        alu_lo = quot;
        alu_hi = rem;
      end
      OP_MUL: begin
        alu_lo = mul_p[W-1:0];
        alu_hi = mul_p[2*W-1:W];
      end
`else
      OP_DIV, OP_MUL: alu_lo = '0;
`endif
      OP_NEG:          alu_lo = W'(0) - bus;
      OP_NOT:          alu_lo = ~bus;
      default:         alu_lo = y_q + bus;
    endcase
  end

  always_comb begin
    case (ir_q[20:19])
      2'b00:   con_eval = (bus == '0);
      2'b01:   con_eval = (bus != '0);
      2'b10:   con_eval = ~bus[W-1] & (bus != '0);
      default: con_eval = bus[W-1];
    endcase
  end

  // Next-state for every architectural register
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = reg_in[i] ? bus : rf_q[i];
    end
    pc_d      = pc_q;
    if (PCin)       pc_d = bus;
    else if (IncPC) pc_d = pc_q + W'(1);
    ir_d      = IRin  ? bus : ir_q;
    mar_d     = MARin ? bus[AW-1:0] : mar_q;
    mdr_d     = mdr_q;
    if (MDRin) mdr_d = memRead ? mem_q[mar_q] : bus;
    y_d       = Yin   ? bus : y_q;
    z_d       = Zin   ? {alu_hi, alu_lo} : z_q;
    hi_d      = HIin  ? bus : hi_q;
    lo_d      = LOin  ? bus : lo_q;
    outport_d = OutPort_In ? bus : outport_q;
    con_d     = CONin ? con_eval : con_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      y_q       <= y_d;
      z_q       <= z_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      inport_q  <= InPortData;
      outport_q <= outport_d;
      con_q     <= con_d;
    end
  end

  // RAM keeps its contents across clear; writes are suppressed while clear is high
  always_ff @(posedge clock) begin
    if (ramEnable && !memRead && !clear) mem_q[mar_q] <= mdr_q;
  end

  assign OutPortData = outport_q;
  assign CON         = con_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: expectations are queued when a micro-op sequence is
// issued and popped when the result is brought out through the out-port or CON.
module tb_cpu_datapath;

`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, MARin, MDRout, MDRin, memRead;
  logic        ramEnable, PCin, PCout, ADD, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout;
  logic        Yin, IRin, Cout, InPort_Out, OutPort_In, CONin, CON;
  logic [15:0] rout, rin;
  logic [31:0] InPortData, OutPortData;

  logic [31:0] exp_q [$];
  string       nm_q  [$];
  logic [31:0] exp_v;
  string       exp_n;
  int          checks = 0;
  int          passed = 0;

  cpu_datapath dut (
    .clock(clock), .clear(clear), .IncPC(IncPC),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .MARin(MARin), .MDRout(MDRout), .MDRin(MDRin), .memRead(memRead), .ramEnable(ramEnable),
    .PCin(PCin), .PCout(PCout), .ADD(ADD), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Yin(Yin), .IRin(IRin), .Cout(Cout),
    .InPortData(InPortData), .InPort_Out(InPort_Out), .OutPortData(OutPortData),
    .OutPort_In(OutPort_In), .CONin(CONin), .CON(CON)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rout = '0; rin = '0; IncPC = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
    MARin = 0; MDRout = 0; MDRin = 0; memRead = 0; ramEnable = 0; PCin = 0; PCout = 0;
    ADD = 0; Zin = 0; Zhighout = 0; Zlowout = 0; HIin = 0; LOin = 0; HIout = 0; LOout = 0;
    Yin = 0; IRin = 0; Cout = 0; InPort_Out = 0; OutPort_In = 0; CONin = 0; clear = 0;
  endtask

  // In-port captures on one edge, then drives the bus on the next
  task automatic stage(input logic [31:0] v);
    InPortData = v;
    tick();
    InPort_Out = 1;
  endtask

  task automatic load_reg(input logic [3:0] n, input logic [31:0] v);
    stage(v); rin[n] = 1; tick(); idle();
  endtask

  task automatic load_ir(input logic [31:0] v);
    stage(v); IRin = 1; tick(); idle();
  endtask

  task automatic to_out();
    OutPort_In = 1; tick(); idle();
  endtask

  task automatic test_reset();
    idle();
    clear = 1; tick(); idle();
    exp_q.push_back(32'h0); nm_q.push_back("reset outport");
    exp_q.push_back(32'h0); nm_q.push_back("reset con");
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if ({31'd0, CON} !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, CON, exp_v);
    else passed++;
    exp_q.push_back(32'h0); nm_q.push_back("reset R5");
    rout[5] = 1; to_out();
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
  endtask

  task automatic test_pc();
    IncPC = 1; tick(); tick(); tick(); idle();
    exp_q.push_back(32'd3); nm_q.push_back("pc increment");
    PCout = 1; to_out();
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
    stage(32'h40); PCin = 1; IncPC = 1; tick(); idle();
    exp_q.push_back(32'h40); nm_q.push_back("pcin over incpc");
    PCout = 1; to_out();
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
  endtask

  task automatic test_select();
    load_reg(4'd0, 32'h55);
    load_reg(4'd2, 32'h22);
    load_reg(4'd3, 32'h33);
    load_ir({5'd0, 4'd2, 4'd0, 4'd9, 15'd0});
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: begin exp_q.push_back(32'h0);  nm_q.push_back("baout r0 zero");   Grb = 1; BAout = 1; end
        1: begin exp_q.push_back(32'h55); nm_q.push_back("rout r0 value");   Grb = 1; Rout = 1; end
        2: begin exp_q.push_back(32'h22); nm_q.push_back("gra over grb");    Gra = 1; Grb = 1; Rout = 1; end
        3: begin exp_q.push_back(32'h22); nm_q.push_back("reg over pc/in");  rout[2] = 1; PCout = 1; InPort_Out = 1; end
        4: begin exp_q.push_back(32'h33); nm_q.push_back("lowest reg wins"); rout[3] = 1; rout[9] = 1; end
        default: begin
          stage(32'hABC); Grc = 1; Rin = 1; tick(); idle();
          exp_q.push_back(32'hABC); nm_q.push_back("grc rin load"); rout[9] = 1;
        end
      endcase
      to_out();
      exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
      if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
      else passed++;
    end
  endtask

  task automatic test_alu();
    logic [4:0]  op;
    logic [31:0] a, b, lo, hi;
    logic        frc;
    for (int k = 0; k < 19; k++) begin
      frc = 0; hi = 32'h0;
      case (k)
        0:  begin op = 5'd3;  a = 32'd5;        b = 32'hFFFFFFFD; lo = 32'd2;        end
        1:  begin op = 5'd4;  a = 32'd5;        b = 32'hFFFFFFFD; lo = 32'd8;        end
        2:  begin op = 5'd5;  a = 32'hF0F000FF; b = 32'h0FF00F0F; lo = 32'h00F0000F; end
        3:  begin op = 5'd6;  a = 32'hF0F000FF; b = 32'h0FF00F0F; lo = 32'hFFF00FFF; end
        4:  begin op = 5'd7;  a = 32'h80000001; b = 32'd33;       lo = 32'hC0000000; end
        5:  begin op = 5'd8;  a = 32'h80000001; b = 32'd33;       lo = 32'h00000003; end
        6:  begin op = 5'd9;  a = 32'h80000001; b = 32'd33;       lo = 32'h40000000; end
        7:  begin op = 5'd10; a = 32'h80000001; b = 32'd33;       lo = 32'hC0000000; end
        8:  begin op = 5'd11; a = 32'h80000001; b = 32'd33;       lo = 32'h00000002; end
        9:  begin op = 5'd7;  a = 32'h12345678; b = 32'd32;       lo = 32'h12345678; end
        10: begin op = 5'd17; a = 32'd7;        b = 32'd5;        lo = 32'hFFFFFFFB; end
        11: begin op = 5'd18; a = 32'd7;        b = 32'd5;        lo = 32'hFFFFFFFA; end
        12: begin op = 5'd4;  a = 32'd10;       b = 32'd3;        lo = 32'd13; frc = 1; end
        13: begin op = 5'd20; a = 32'hFFFFFFFF; b = 32'd2;        lo = 32'd1;        end
        14: begin op = 5'd12; a = 32'd1;        b = 32'd2;        lo = 32'd3;        end
        15: begin op = 5'd16; a = 32'hFFFFFFFA; b = 32'd7;
                  lo = MD ? 32'hFFFFFFD6 : 32'h0; hi = MD ? 32'hFFFFFFFF : 32'h0; end
        16: begin op = 5'd15; a = 32'd17;       b = 32'd5;
                  lo = MD ? 32'd3 : 32'h0; hi = MD ? 32'd2 : 32'h0; end
        17: begin op = 5'd15; a = 32'hFFFFFFEF; b = 32'd5;
                  lo = MD ? 32'hFFFFFFFD : 32'h0; hi = MD ? 32'hFFFFFFFE : 32'h0; end
        default: begin op = 5'd15; a = 32'd17; b = 32'd0; lo = 32'h0; end
      endcase
      load_reg(4'd1, a);
      load_reg(4'd2, b);
      load_ir({op, 4'd3, 4'd1, 4'd2, 15'd0});
      Grb = 1; Rout = 1; Yin = 1; tick(); idle();
      Grc = 1; Rout = 1; Zin = 1; ADD = frc; tick(); idle();
      exp_q.push_back(lo); nm_q.push_back($sformatf("alu%0d op%0d zlo", k, op));
      exp_q.push_back(hi); nm_q.push_back($sformatf("alu%0d op%0d zhi", k, op));
      Zlowout = 1; to_out();
      exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
      if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
      else passed++;
      Zhighout = 1; to_out();
      exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
      if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
      else passed++;
    end
  endtask

  task automatic test_ori();
    load_reg(4'd4, 32'hB7);
    load_ir(32'h71A00053);
    Grb = 1; Rout = 1; Yin = 1; tick(); idle();
    Cout = 1; Zin = 1; tick(); idle();
    Zlowout = 1; Gra = 1; Rin = 1; tick(); idle();
    exp_q.push_back(32'hF7); nm_q.push_back("ori R3");
    rout[3] = 1; to_out();
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
  endtask

  task automatic test_hilo();
    logic [4:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? 5'd16 : 5'd15;
      a  = (k == 0) ? 32'hFFFFFFFA : 32'd17;
      b  = (k == 0) ? 32'd7 : 32'd5;
      load_reg(4'd1, a);
      load_reg(4'd2, b);
      load_ir({op, 4'd0, 4'd1, 4'd2, 15'd0});
      Grb = 1; Rout = 1; Yin = 1; tick(); idle();
      Grc = 1; Rout = 1; Zin = 1; tick(); idle();
      exp_q.push_back(!MD ? 32'h0 : (k == 0) ? 32'hFFFFFFFF : 32'd2); nm_q.push_back($sformatf("hi op%0d", op));
      exp_q.push_back(!MD ? 32'h0 : (k == 0) ? 32'hFFFFFFD6 : 32'd3); nm_q.push_back($sformatf("lo op%0d", op));
      Zhighout = 1; HIin = 1; tick(); idle();
      Zlowout = 1; LOin = 1; tick(); idle();
      HIout = 1; to_out();
      exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
      if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
      else passed++;
      LOout = 1; to_out();
      exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
      if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
      else passed++;
    end
  endtask

  task automatic test_mem();
    stage(32'h10);   MARin = 1; tick(); idle();
    stage(32'hCAFE); MDRin = 1; tick(); idle();
    ramEnable = 1; tick(); idle();
    stage(32'h11);   MARin = 1; tick(); idle();
    stage(32'hBEEF); MDRin = 1; tick(); idle();
    ramEnable = 1; tick(); idle();
    exp_q.push_back(32'hBEEF); nm_q.push_back("mdr bus load");
    MDRout = 1; to_out();
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
    // 0x210 aliases 0x10 through the 9-bit RAM address
    stage(32'h210); MARin = 1; tick(); idle();
    memRead = 1; MDRin = 1; tick(); idle();
    load_ir({5'd1, 4'd6, 23'd0});
    MDRout = 1; Gra = 1; Rin = 1; tick(); idle();
    exp_q.push_back(32'hCAFE); nm_q.push_back("ld Ra");
    rout[6] = 1; to_out();
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
    stage(32'h11); MARin = 1; tick(); idle();
    memRead = 1; MDRin = 1; ramEnable = 1; tick(); idle();
    exp_q.push_back(32'hBEEF); nm_q.push_back("ld second word");
    MDRout = 1; to_out();
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
  endtask

  task automatic test_con();
    logic [1:0]  c2;
    logic [31:0] v;
    logic        e;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: begin c2 = 2'b00; v = 32'h0;        e = 1; end
        1: begin c2 = 2'b11; v = 32'h80000000; e = 1; end
        2: begin c2 = 2'b10; v = 32'h0;        e = 0; end
        3: begin c2 = 2'b01; v = 32'd5;        e = 1; end
        4: begin c2 = 2'b10; v = 32'h80000000; e = 0; end
        5: begin c2 = 2'b10; v = 32'd1;        e = 1; end
        default: begin c2 = 2'b11; v = 32'd7;  e = 0; end
      endcase
      load_ir({11'd0, c2, 19'd0});
      stage(v); CONin = 1; tick(); idle();
      exp_q.push_back({31'd0, e}); nm_q.push_back($sformatf("con c2=%0d bus=%h", c2, v));
      exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
      if ({31'd0, CON} !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, CON, exp_v);
      else passed++;
    end
  endtask

  task automatic test_clear_mid();
    load_reg(4'd7, 32'h77);
    stage(32'h100); PCin = 1; tick(); idle();
    stage(32'd1); Yin = 1; tick(); idle();
    stage(32'd2); Zin = 1; ADD = 1; tick(); idle();
    load_ir(32'h0);
    CONin = 1; tick(); idle();
    exp_q.push_back(32'd1); nm_q.push_back("con before clear");
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if ({31'd0, CON} !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, CON, exp_v);
    else passed++;
    exp_q.push_back(32'd3); nm_q.push_back("z before clear");
    Zlowout = 1; to_out();
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
    // clear wins over a simultaneous register load
    stage(32'h1234); rin[7] = 1; clear = 1; tick(); idle();
    exp_q.push_back(32'h0); nm_q.push_back("clear outport");
    exp_q.push_back(32'h0); nm_q.push_back("clear con");
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
    else passed++;
    exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
    if ({31'd0, CON} !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, CON, exp_v);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin rout[7] = 1;  nm_q.push_back("clear R7"); end
        1: begin PCout = 1;    nm_q.push_back("clear PC"); end
        2: begin Zlowout = 1;  nm_q.push_back("clear Zlo"); end
        default: begin Yin = 0; Cout = 1; nm_q.push_back("clear IR C"); end
      endcase
      exp_q.push_back(32'h0);
      to_out();
      exp_v = exp_q.pop_front(); exp_n = nm_q.pop_front(); checks++;
      if (OutPortData !== exp_v) $display("FAIL %s: got %h expected %h", exp_n, OutPortData, exp_v);
      else passed++;
    end
  endtask

  initial begin
    InPortData = '0;
    idle();
    clear = 1;
    tick();
    test_reset();
    test_pc();
    test_select();
    test_alu();
    test_ori();
    test_hilo();
    test_mem();
    test_con();
    test_clear_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
